// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game referee and its score counters.
package game_pkg;

  localparam int unsigned SCORE_W = 3;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 3'd7;

  typedef enum logic [2:0] {
    COUNTDOWN,
    ARMED,
    SCORE,
    SETTLE,
    GAMEOVER
  } ref_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    TIE  = 2'b11
  } winner_t;

endpackage

// File: rtl/round_timer.sv
// Loadable down-counter for the pre-go countdown; done while the count is zero.
module round_timer #(
  parameter int unsigned DELAY_CYCLES = 8
) (
  input  logic clk,
  input  logic load,
  output logic done
);

  localparam int unsigned W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(DELAY_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load)
      cnt <= LOAD_VAL;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/round_referee.sv
// Round sequencer and first-press arbiter for the two-player reaction game.
// Optional macro FALSE_START_EN: a press during the countdown awards the round to the opponent.
module round_referee
  import game_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p1_press,
  input  logic               p2_press,
  input  logic [SCORE_W-1:0] p1_score,
  input  logic [SCORE_W-1:0] p2_score,
  output logic               go,
  output logic               p1_win,
  output logic               p1_lose,
  output logic               p2_win,
  output logic               p2_lose,
  output logic [1:0]         winner,
  output logic               game_over
);

  ref_state_t state_q, state_d;
  winner_t    winner_q, winner_d;
  logic       timer_done;
  logic       timer_load;

  // Timer is held at its reload value outside COUNTDOWN, so every entry starts a full count.
  assign timer_load = reset || (state_q != COUNTDOWN);

  round_timer #(.DELAY_CYCLES(DELAY_CYCLES)) u_timer (
    .clk  (clk),
    .load (timer_load),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COUNTDOWN;
      winner_q <= NONE;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    go        = 1'b0;
    p1_win    = 1'b0;
    p1_lose   = 1'b0;
    p2_win    = 1'b0;
    p2_lose   = 1'b0;
    game_over = 1'b0;
    unique case (state_q)
      COUNTDOWN: begin
`ifdef FALSE_START_EN
        if (p1_press && p2_press) begin
          winner_d = TIE;
          state_d  = SETTLE;
        end else if (p1_press) begin
          winner_d = P2;
          state_d  = SCORE;
        end else if (p2_press) begin
          winner_d = P1;
          state_d  = SCORE;
        end else if (timer_done) begin
          state_d = ARMED;
        end
`else
        if (timer_done)
          state_d = ARMED;
`endif
      end
      ARMED: begin
        go = 1'b1;
        if (p1_press && p2_press) begin
          winner_d = TIE;
          state_d  = SETTLE;
        end else if (p1_press) begin
          winner_d = P1;
          state_d  = SCORE;
        end else if (p2_press) begin
          winner_d = P2;
          state_d  = SCORE;
        end
      end
      SCORE: begin
        p1_win  = (winner_q == P1);
        p2_lose = (winner_q == P1);
        p2_win  = (winner_q == P2);
        p1_lose = (winner_q == P2);
        state_d = SETTLE;
      end
      SETTLE: begin
        if ((p1_score == SCORE_MAX) || (p2_score == SCORE_MAX))
          state_d = GAMEOVER;
        else
          state_d = COUNTDOWN;
      end
      GAMEOVER: begin
        game_over = 1'b1;
      end
      default: state_d = COUNTDOWN;
    endcase
  end

  assign winner = winner_q;

endmodule
